// File: rtl/cmd_arbiter_if.sv
// Bundle of the two requester ports (A and B) and the cmdcontrol-facing
// handshake shared by cmd_arbiter. The arbiter uses the slave view; the
// surrounding host logic or a testbench drives through the master view.
interface cmd_arbiter_if;
  logic        iReq_a;
  logic        iReq_b;
  logic [5:0]  iIndex_a;
  logic [5:0]  iIndex_b;
  logic [31:0] iArg_a;
  logic [31:0] iArg_b;
  logic        oDone_a;
  logic        oDone_b;
  logic        oGrant_b;
  logic [47:0] oResponse;
  logic        oErr_timeout;
  logic        oErr_index;
  logic        oNew_command;
  logic [5:0]  oCmd_index;
  logic [31:0] oCmd_argument;
  logic        oTimeout_enable;
  logic        oTimeout;
  logic        iIdle_out;
  logic        iCommand_complete;
  logic [47:0] iResponse;
  logic        iCommand_index_error;

  modport slave (
    input  iReq_a, iReq_b, iIndex_a, iIndex_b, iArg_a, iArg_b,
    input  iIdle_out, iCommand_complete, iResponse, iCommand_index_error,
    output oDone_a, oDone_b, oGrant_b, oResponse, oErr_timeout, oErr_index,
    output oNew_command, oCmd_index, oCmd_argument, oTimeout_enable, oTimeout
  );

  modport master (
    output iReq_a, iReq_b, iIndex_a, iIndex_b, iArg_a, iArg_b,
    output iIdle_out, iCommand_complete, iResponse, iCommand_index_error,
    input  oDone_a, oDone_b, oGrant_b, oResponse, oErr_timeout, oErr_index,
    input  oNew_command, oCmd_index, oCmd_argument, oTimeout_enable, oTimeout
  );
endinterface

// File: rtl/cmd_arbiter.sv
// cmd_arbiter: shares one cmdcontrol between requester A (register path)
// and requester B (data/DMA path). Grants one command at a time, issues it,
// runs the response timeout and hands the result back to the granted side.
// Every output comes straight from a flop.
module cmd_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16,
  parameter bit FIXED_PRIO     = 1'b0
) (
  input logic          iClock_host,
  input logic          iReset,
  cmd_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } stateT;

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

  stateT       state, nextState;
  logic [CNT_W-1:0] count, nextCount;
  logic        prioB, nextPrioB;
  logic        grantB, nextGrantB;
  logic        doneA, nextDoneA;
  logic        doneB, nextDoneB;
  logic        newCommand, nextNewCommand;
  logic        timeoutEnable, nextTimeoutEnable;
  logic        timeoutPulse, nextTimeoutPulse;
  logic        errTimeout, nextErrTimeout;
  logic        errIndex, nextErrIndex;
  logic [5:0]  cmdIndex, nextCmdIndex;
  logic [31:0] cmdArgument, nextCmdArgument;
  logic [47:0] response, nextResponse;
  logic        pickB;
  logic        finish;

  // Next-state and next-output logic; pulses default low, everything else holds.
  always_comb begin
    nextState         = state;
    nextCount         = count;
    nextPrioB         = prioB;
    nextGrantB        = grantB;
    nextDoneA         = 1'b0;
    nextDoneB         = 1'b0;
    nextNewCommand    = 1'b0;
    nextTimeoutEnable = timeoutEnable;
    nextTimeoutPulse  = 1'b0;
    nextErrTimeout    = errTimeout;
    nextErrIndex      = errIndex;
    nextCmdIndex      = cmdIndex;
    nextCmdArgument   = cmdArgument;
    nextResponse      = response;
    pickB             = 1'b0;
    finish            = 1'b0;

    case (state)
      IDLE: begin
        if (bus.iReq_b && !bus.iReq_a) begin
          pickB = 1'b1;
        end else if (bus.iReq_a && bus.iReq_b) begin
          pickB = FIXED_PRIO ? 1'b0 : prioB;
        end
        if (bus.iIdle_out && (bus.iReq_a || bus.iReq_b)) begin
          nextGrantB      = pickB;
          nextCmdIndex    = pickB ? bus.iIndex_b : bus.iIndex_a;
          nextCmdArgument = pickB ? bus.iArg_b : bus.iArg_a;
          nextCount       = '0;
          nextNewCommand  = 1'b1;
          nextState       = ISSUE;
        end
      end
      ISSUE: begin
        nextTimeoutEnable = 1'b1;
        nextState         = WAIT;
      end
      WAIT: begin
        nextCount = count + CNT_W'(1);
        if (bus.iCommand_complete) begin
          nextResponse   = bus.iResponse;
          nextErrIndex   = bus.iCommand_index_error;
          nextErrTimeout = 1'b0;
          finish         = 1'b1;
        end else if (bus.iCommand_index_error) begin
          nextErrIndex   = 1'b1;
          nextErrTimeout = 1'b0;
          finish         = 1'b1;
        end else if (count == LAST_COUNT) begin
          nextTimeoutPulse = 1'b1;
          nextErrTimeout   = 1'b1;
          nextErrIndex     = 1'b0;
          finish           = 1'b1;
        end
        if (finish) begin
          nextTimeoutEnable = 1'b0;
          nextDoneA         = !grantB;
          nextDoneB         = grantB;
          nextState         = DONE;
        end
      end
      DONE: begin
        nextPrioB = !grantB;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // State and output registers; reset drops everything straight to idle.
  always_ff @(posedge iClock_host or negedge iReset) begin
    if (!iReset) begin
      state         <= IDLE;
      count         <= '0;
      prioB         <= 1'b0;
      grantB        <= 1'b0;
      doneA         <= 1'b0;
      doneB         <= 1'b0;
      newCommand    <= 1'b0;
      timeoutEnable <= 1'b0;
      timeoutPulse  <= 1'b0;
      errTimeout    <= 1'b0;
      errIndex      <= 1'b0;
      cmdIndex      <= '0;
      cmdArgument   <= '0;
      response      <= '0;
    end else begin
      state         <= nextState;
      count         <= nextCount;
      prioB         <= nextPrioB;
      grantB        <= nextGrantB;
      doneA         <= nextDoneA;
      doneB         <= nextDoneB;
      newCommand    <= nextNewCommand;
      timeoutEnable <= nextTimeoutEnable;
      timeoutPulse  <= nextTimeoutPulse;
      errTimeout    <= nextErrTimeout;
      errIndex      <= nextErrIndex;
      cmdIndex      <= nextCmdIndex;
      cmdArgument   <= nextCmdArgument;
      response      <= nextResponse;
    end
  end

  assign bus.oDone_a         = doneA;
  assign bus.oDone_b         = doneB;
  assign bus.oGrant_b        = grantB;
  assign bus.oResponse       = response;
  assign bus.oErr_timeout    = errTimeout;
  assign bus.oErr_index      = errIndex;
  assign bus.oNew_command    = newCommand;
  assign bus.oCmd_index      = cmdIndex;
  assign bus.oCmd_argument   = cmdArgument;
  assign bus.oTimeout_enable = timeoutEnable;
  assign bus.oTimeout        = timeoutPulse;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Testbench for cmd_arbiter. Two instances see identical inputs:
// dutM is round-robin with a long timeout, dutT is fixed-priority with an
// 8-cycle timeout. Inputs change and outputs are sampled on the falling edge.
module tb_cmd_arbiter;

  logic clk;
  logic rstN;
  int   checks = 0;
  int   errors = 0;

  cmd_arbiter_if busM();
  cmd_arbiter_if busT();

  cmd_arbiter #(.TIMEOUT_CYCLES(1024), .CNT_W(16), .FIXED_PRIO(1'b0)) dutM (
    .iClock_host(clk), .iReset(rstN), .bus(busM.slave));
  cmd_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(4), .FIXED_PRIO(1'b1)) dutT (
    .iClock_host(clk), .iReset(rstN), .bus(busT.slave));

  assign busT.iReq_a               = busM.iReq_a;
  assign busT.iReq_b               = busM.iReq_b;
  assign busT.iIndex_a             = busM.iIndex_a;
  assign busT.iIndex_b             = busM.iIndex_b;
  assign busT.iArg_a               = busM.iArg_a;
  assign busT.iArg_b               = busM.iArg_b;
  assign busT.iIdle_out            = busM.iIdle_out;
  assign busT.iCommand_complete    = busM.iCommand_complete;
  assign busT.iResponse            = busM.iResponse;
  assign busT.iCommand_index_error = busM.iCommand_index_error;

  // Flag vectors: [7]doneA [6]doneB [5]grantB [4]errTimeout [3]errIndex [2]newCmd [1]toEnable [0]timeout
  logic [7:0] flagsM, flagsT;
  assign flagsM = {busM.oDone_a, busM.oDone_b, busM.oGrant_b, busM.oErr_timeout,
                   busM.oErr_index, busM.oNew_command, busM.oTimeout_enable, busM.oTimeout};
  assign flagsT = {busT.oDone_a, busT.oDone_b, busT.oGrant_b, busT.oErr_timeout,
                   busT.oErr_index, busT.oNew_command, busT.oTimeout_enable, busT.oTimeout};

  // Free-running 100 MHz host clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something never returns
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clearInputs();
    busM.iReq_a = 0; busM.iReq_b = 0;
    busM.iIndex_a = 0; busM.iIndex_b = 0;
    busM.iArg_a = 0; busM.iArg_b = 0;
    busM.iIdle_out = 1;
    busM.iCommand_complete = 0;
    busM.iResponse = 0;
    busM.iCommand_index_error = 0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rstN = 0;
    clearInputs();
    repeat (2) @(negedge clk);
    rstN = 1;
    @(negedge clk);
  endtask

  // Runs one command on the shared inputs; returns at the falling edge of the DONE cycle.
  task automatic driveTxn(input bit rA, input bit rB, input logic [5:0] idxA, input logic [5:0] idxB,
                          input logic [31:0] argA, input logic [31:0] argB,
                          input int busy, input int delay, input bit cmpl, input bit err,
                          input logic [47:0] resp,
                          output bit issued, output bit early, output bit gB, output bit gBT,
                          output logic [5:0] gIdx, output logic [31:0] gArg);
    issued = 0; early = 0; gB = 0; gBT = 0; gIdx = 0; gArg = 0;
    busM.iReq_a = rA; busM.iReq_b = rB;
    busM.iIndex_a = idxA; busM.iIndex_b = idxB;
    busM.iArg_a = argA; busM.iArg_b = argB;
    busM.iIdle_out = (busy == 0);
    for (int k = 0; k < busy; k++) begin
      @(negedge clk);
      if (busM.oNew_command) early = 1;
    end
    busM.iIdle_out = 1;
    for (int k = 0; k < 4 && !issued; k++) begin
      @(negedge clk);
      if (busM.oNew_command) begin
        issued = 1;
        gB = busM.oGrant_b;
        gBT = busT.oGrant_b;
        gIdx = busM.oCmd_index;
        gArg = busM.oCmd_argument;
      end
    end
    if (!issued) begin
      busM.iReq_a = 0; busM.iReq_b = 0;
      return;
    end
    @(negedge clk);
    repeat (delay) @(negedge clk);
    busM.iCommand_complete = cmpl;
    busM.iCommand_index_error = err;
    busM.iResponse = resp;
    @(negedge clk);
    busM.iCommand_complete = 0;
    busM.iCommand_index_error = 0;
    busM.iReq_a = 0; busM.iReq_b = 0;
  endtask

  task automatic test_reset();
    rstN = 0;
    clearInputs();
    #1;
    checks++;
    if (flagsM !== 8'h00 || flagsT !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_flags: got M=%b T=%b, want 0", flagsM, flagsT);
    end
    checks++;
    if (busM.oResponse !== 48'h0 || busM.oCmd_index !== 6'h0 || busM.oCmd_argument !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_data: resp=%h idx=%h arg=%h, want 0",
                         busM.oResponse, busM.oCmd_index, busM.oCmd_argument);
    end
    busM.iReq_a = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (flagsM !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_hold: got %b while reset held, want 0", flagsM);
    end
    rstN = 1;
    busM.iReq_a = 0;
    @(negedge clk);
  endtask

  task automatic test_single_a();
    doReset();
    busM.iReq_a = 1; busM.iIndex_a = 6'd17; busM.iArg_a = 32'h0000_0200;
    busM.iIndex_b = 6'd5; busM.iArg_b = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (flagsM[2] !== 1'b1 || busM.oGrant_b !== 1'b0) begin
      errors++; $display("[TB] FAIL single_issue: newCmd=%b grantB=%b, want 1/0", flagsM[2], busM.oGrant_b);
    end
    checks++;
    if (busM.oCmd_index !== 6'd17 || busM.oCmd_argument !== 32'h0000_0200) begin
      errors++; $display("[TB] FAIL single_latch: idx=%0d arg=%h, want 17/00000200",
                         busM.oCmd_index, busM.oCmd_argument);
    end
    @(negedge clk);
    checks++;
    if (flagsM[2:1] !== 2'b01) begin
      errors++; $display("[TB] FAIL single_wait: newCmd,toEn=%b, want 01", flagsM[2:1]);
    end
    repeat (18) @(negedge clk);
    checks++;
    if (flagsM[7:6] !== 2'b00 || flagsM[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL single_early_done: flags=%b, want no done/timeout", flagsM);
    end
    busM.iCommand_complete = 1; busM.iResponse = 48'h11_0000_0900_01;
    @(negedge clk);
    busM.iCommand_complete = 0; busM.iReq_a = 0;
    checks++;
    if (flagsM[7:6] !== 2'b10 || flagsM[4] !== 1'b0 || flagsM[1] !== 1'b0) begin
      errors++; $display("[TB] FAIL single_done: flags=%b, want doneA, no errTimeout, toEn low", flagsM);
    end
    checks++;
    if (busM.oResponse !== 48'h11_0000_0900_01) begin
      errors++; $display("[TB] FAIL single_resp: got %h, want 110000090001", busM.oResponse);
    end
    @(negedge clk);
    checks++;
    if (flagsM[7:6] !== 2'b00) begin
      errors++; $display("[TB] FAIL single_pulse: done=%b one cycle later, want 00", flagsM[7:6]);
    end
  endtask

  task automatic test_round_robin();
    bit issued, early, gB, gBT;
    logic [5:0] gIdx;
    logic [31:0] gArg;
    doReset();
    for (int i = 0; i < 4; i++) begin
      driveTxn(1, 1, 6'(i), 6'(32 + i), 32'(100 + i), 32'(200 + i), 0, 2, 1, 0, 48'(i + 1),
               issued, early, gB, gBT, gIdx, gArg);
      checks++;
      if (!issued || gB !== i[0] || gIdx !== (i[0] ? 6'(32 + i) : 6'(i))) begin
        errors++; $display("[TB] FAIL rr_grant[%0d]: issued=%b grantB=%b idx=%0d, want grantB=%b",
                           i, issued, gB, gIdx, i[0]);
      end
      checks++;
      if (flagsM[7:6] !== (i[0] ? 2'b01 : 2'b10)) begin
        errors++; $display("[TB] FAIL rr_done[%0d]: doneA,doneB=%b", i, flagsM[7:6]);
      end
      checks++;
      if (gBT !== 1'b0 || flagsT[7:6] !== 2'b10) begin
        errors++; $display("[TB] FAIL fixed_prio[%0d]: grantB=%b done=%b, want 0/10", i, gBT, flagsT[7:6]);
      end
    end
  endtask

  task automatic test_timeout();
    doReset();
    busM.iReq_a = 1; busM.iIndex_a = 6'd3;
    @(negedge clk);
    checks++;
    if (flagsT[2] !== 1'b1) begin
      errors++; $display("[TB] FAIL to_issue: newCmd=%b, want 1", flagsT[2]);
    end
    @(negedge clk);
    repeat (7) @(negedge clk);
    checks++;
    if (flagsT[1:0] !== 2'b10) begin
      errors++; $display("[TB] FAIL to_before: toEn,timeout=%b, want 10", flagsT[1:0]);
    end
    @(negedge clk);
    busM.iReq_a = 0;
    checks++;
    if (flagsT[0] !== 1'b1 || flagsT[4] !== 1'b1 || flagsT[7:6] !== 2'b10 || flagsT[1] !== 1'b0) begin
      errors++; $display("[TB] FAIL to_pulse: flags=%b, want timeout, errTimeout, doneA", flagsT);
    end
    @(negedge clk);
    checks++;
    if (flagsT[0] !== 1'b0 || flagsT[7:6] !== 2'b00) begin
      errors++; $display("[TB] FAIL to_after: flags=%b, want pulses cleared", flagsT);
    end
  endtask

  // Runs straight after test_timeout so errTimeout starts at 1
  task automatic test_complete_at_limit();
    logic [63:0] r64;
    r64 = {$urandom(), $urandom()};
    busM.iReq_a = 1;
    @(negedge clk);
    checks++;
    if (flagsT[2] !== 1'b1) begin
      errors++; $display("[TB] FAIL lim_issue: newCmd=%b after timeout, want 1", flagsT[2]);
    end
    @(negedge clk);
    repeat (7) @(negedge clk);
    busM.iCommand_complete = 1; busM.iResponse = r64[47:0];
    @(negedge clk);
    busM.iCommand_complete = 0; busM.iReq_a = 0;
    checks++;
    if (flagsT[0] !== 1'b0 || flagsT[4] !== 1'b0 || flagsT[7:6] !== 2'b10) begin
      errors++; $display("[TB] FAIL lim_flags: flags=%b, want no timeout, errTimeout 0, doneA", flagsT);
    end
    checks++;
    if (busT.oResponse !== r64[47:0]) begin
      errors++; $display("[TB] FAIL lim_resp: got %h, want %h", busT.oResponse, r64[47:0]);
    end
  endtask

  task automatic test_index_error();
    bit issued, early, gB, gBT;
    logic [5:0] gIdx;
    logic [31:0] gArg;
    doReset();
    driveTxn(1, 0, 6'd8, 6'd0, 32'h1, 32'h0, 0, 1, 1, 1, 48'hAAAA_0000_0001,
             issued, early, gB, gBT, gIdx, gArg);
    checks++;
    if (!issued || busM.oErr_index !== 1'b1 || busM.oResponse !== 48'hAAAA_0000_0001) begin
      errors++; $display("[TB] FAIL idx_err: issued=%b errIndex=%b resp=%h, want 1/1/aaaa00000001",
                         issued, busM.oErr_index, busM.oResponse);
    end
    driveTxn(1, 0, 6'd9, 6'd0, 32'h2, 32'h0, 0, 3, 1, 0, 48'hBBBB_0000_0002,
             issued, early, gB, gBT, gIdx, gArg);
    checks++;
    if (!issued || busM.oErr_index !== 1'b0 || busM.oResponse !== 48'hBBBB_0000_0002) begin
      errors++; $display("[TB] FAIL idx_clear: issued=%b errIndex=%b resp=%h, want 1/0/bbbb00000002",
                         issued, busM.oErr_index, busM.oResponse);
    end
    driveTxn(1, 0, 6'd10, 6'd0, 32'h3, 32'h0, 0, 2, 0, 1, 48'hCCCC_0000_0003,
             issued, early, gB, gBT, gIdx, gArg);
    checks++;
    if (!issued || busM.oErr_index !== 1'b1 || busM.oResponse !== 48'hBBBB_0000_0002 ||
        flagsM[7:6] !== 2'b10) begin
      errors++; $display("[TB] FAIL idx_alone: errIndex=%b resp=%h done=%b, want 1/bbbb00000002/10",
                         busM.oErr_index, busM.oResponse, flagsM[7:6]);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit issued, early, gB, gBT;
    logic [5:0] gIdx;
    logic [31:0] gArg;
    doReset();
    driveTxn(1, 0, 6'd4, 6'd0, 32'h4, 32'h0, 0, 1, 1, 0, 48'h1234_5678_9ABC,
             issued, early, gB, gBT, gIdx, gArg);
    busM.iReq_b = 1; busM.iIndex_b = 6'd45; busM.iArg_b = 32'h5555_0000;
    repeat (3) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (flagsM[1] !== 1'b1 || busM.oGrant_b !== 1'b1) begin
      errors++; $display("[TB] FAIL abort_setup: toEn=%b grantB=%b, want 1/1", flagsM[1], busM.oGrant_b);
    end
    rstN = 0;
    #1;
    checks++;
    if (flagsM !== 8'h00 || busM.oCmd_index !== 6'h0 || busM.oCmd_argument !== 32'h0 ||
        busM.oResponse !== 48'h0) begin
      errors++; $display("[TB] FAIL abort_clear: flags=%b idx=%h arg=%h resp=%h, want all 0",
                         flagsM, busM.oCmd_index, busM.oCmd_argument, busM.oResponse);
    end
    busM.iCommand_complete = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (flagsM !== 8'h00) begin
      errors++; $display("[TB] FAIL abort_nodone: flags=%b during reset, want 0", flagsM);
    end
    clearInputs();
    rstN = 1;
    @(negedge clk);
    driveTxn(1, 1, 6'd12, 6'd13, 32'hA, 32'hB, 0, 2, 1, 0, 48'h0000_0000_BEEF,
             issued, early, gB, gBT, gIdx, gArg);
    checks++;
    if (!issued || gB !== 1'b0 || gIdx !== 6'd12 || flagsM[7:6] !== 2'b10 ||
        busM.oResponse !== 48'h0000_0000_BEEF) begin
      errors++; $display("[TB] FAIL abort_recover: issued=%b grantB=%b idx=%0d done=%b resp=%h",
                         issued, gB, gIdx, flagsM[7:6], busM.oResponse);
    end
  endtask

  task automatic test_random();
    bit issued, early, gB, gBT;
    logic [5:0] gIdx;
    logic [31:0] gArg;
    bit rA, rB, err, cmpl, wantB, wantBT, anyGrant, lastB, expErrIdx;
    logic [5:0] idxA, idxB;
    logic [31:0] argA, argB;
    logic [47:0] resp, expResp;
    logic [63:0] r64;
    int busy, delay;
    doReset();
    anyGrant = 0; lastB = 0; expResp = 48'h0; expErrIdx = 0;
    for (int n = 0; n < 40; n++) begin
      rA = 1'($urandom_range(0, 1));
      rB = 1'($urandom_range(0, 1));
      if (!rA && !rB) rA = 1;
      idxA = 6'($urandom()); idxB = 6'($urandom());
      argA = $urandom(); argB = $urandom();
      busy = $urandom_range(0, 3);
      delay = $urandom_range(0, 5);
      err = ($urandom_range(0, 3) == 0);
      cmpl = err ? 1'($urandom_range(0, 1)) : 1'b1;
      r64 = {$urandom(), $urandom()};
      resp = r64[47:0];
      wantB = rB && (!rA || (anyGrant && !lastB));
      wantBT = !rA;
      if (cmpl) begin
        expResp = resp;
        expErrIdx = err;
      end else begin
        expErrIdx = 1;
      end
      driveTxn(rA, rB, idxA, idxB, argA, argB, busy, delay, cmpl, err, resp,
               issued, early, gB, gBT, gIdx, gArg);
      checks++;
      if (!issued || early) begin
        errors++; $display("[TB] FAIL rnd_issue[%0d]: issued=%b earlyWhileBusy=%b", n, issued, early);
      end
      checks++;
      if (gB !== wantB || gIdx !== (wantB ? idxB : idxA) || gArg !== (wantB ? argB : argA)) begin
        errors++; $display("[TB] FAIL rnd_grant[%0d]: grantB=%b idx=%h arg=%h, want %b %h %h",
                           n, gB, gIdx, gArg, wantB, wantB ? idxB : idxA, wantB ? argB : argA);
      end
      checks++;
      if (gBT !== wantBT) begin
        errors++; $display("[TB] FAIL rnd_fixed[%0d]: grantB=%b, want %b", n, gBT, wantBT);
      end
      checks++;
      if (flagsM[7:6] !== {!wantB, wantB} || flagsM[4] !== 1'b0 || busM.oErr_index !== expErrIdx ||
          busM.oResponse !== expResp) begin
        errors++; $display("[TB] FAIL rnd_result[%0d]: done=%b errTo=%b errIdx=%b resp=%h, want %b 0 %b %h",
                           n, flagsM[7:6], flagsM[4], busM.oErr_index, busM.oResponse,
                           {!wantB, wantB}, expErrIdx, expResp);
      end
      anyGrant = 1;
      lastB = wantB;
    end
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_single_a();
    test_round_robin();
    test_timeout();
    test_complete_at_limit();
    test_index_error();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
